// File: rtl/rggen_external_mailbox.sv
// External-register mailbox: TX FIFO (bus -> host), RX FIFO (host -> bus), status and IRQ registers.
// Optional macro RGGEN_MAILBOX_ERROR_RESPONSE_EN: TX overflow / RX underflow complete with SLVERR.
module rggen_external_mailbox #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_request,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic [3:0]               i_strobe,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic [1:0]               o_status,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [DATA_WIDTH-1:0]    o_tx_data,
  input  logic                     i_rx_valid,
  output logic                     o_rx_ready,
  input  logic [DATA_WIDTH-1:0]    i_rx_data,
  output logic                     o_irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = ADDRESS_WIDTH - 2;
  localparam logic [IW-1:0] IDX_TX     = IW'(0);
  localparam logic [IW-1:0] IDX_RX     = IW'(1);
  localparam logic [IW-1:0] IDX_STATUS = IW'(2);
  localparam logic [IW-1:0] IDX_IRQ_EN = IW'(3);
`ifdef RGGEN_MAILBOX_ERROR_RESPONSE_EN
  localparam bit FLOW_ERROR = 1'b1;
`else
  localparam bit FLOW_ERROR = 1'b0;
`endif

  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] tx_count, rx_count, tx_count_next, rx_count_next;
  logic [1:0]    irq_en, irq_en_next;
  logic          irq;
  logic [DATA_WIDTH-1:0] resp_data, rdata, status_word, tx_wdata;
  logic [1:0]    resp_status;
  logic          access, illegal, tx_push_req, rx_pop_req, irq_en_wr;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, tx_overflow, rx_underflow;
  logic [IW-1:0] word_idx;
  logic          unused_addr;

  assign unused_addr = ^i_address[1:0];
  assign word_idx    = i_address[ADDRESS_WIDTH-1:2];
  assign access      = (state == IDLE) && i_request;

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_push      = tx_push_req && !tx_full;
  assign tx_overflow  = tx_push_req && tx_full;
  assign tx_pop       = i_tx_ready && !tx_empty;
  assign rx_pop       = rx_pop_req && !rx_empty;
  assign rx_underflow = rx_pop_req && rx_empty;
  assign rx_push      = i_rx_valid && !rx_full;

  assign o_done      = (state == RESP);
  assign o_read_data = resp_data;
  assign o_status    = resp_status;
  assign o_tx_valid  = !tx_empty;
  assign o_rx_ready  = !rx_full;
  assign o_tx_data   = tx_mem[tx_rptr];
  assign o_irq       = irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_request) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = rx_full;
    status_word[3]     = rx_empty;
    status_word[12:8]  = 5'(tx_count);
    status_word[20:16] = 5'(rx_count);
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      tx_wdata[8*i +: 8] = i_strobe[i] ? i_write_data[8*i +: 8] : 8'h00;
  end

  always_comb begin
    illegal     = 1'b0;
    tx_push_req = 1'b0;
    rx_pop_req  = 1'b0;
    irq_en_wr   = 1'b0;
    rdata       = '0;
    if (access) begin
      case (word_idx)
        IDX_TX:     if (i_write) tx_push_req = 1'b1; else illegal = 1'b1;
        IDX_RX:     if (i_write) illegal = 1'b1; else rx_pop_req = 1'b1;
        IDX_STATUS: if (i_write) illegal = 1'b1; else rdata = status_word;
        IDX_IRQ_EN: if (i_write) irq_en_wr = i_strobe[0];
                    else rdata = {{(DATA_WIDTH-2){1'b0}}, irq_en};
        default:    illegal = 1'b1;
      endcase
      if (rx_pop) rdata = rx_mem[rx_rptr];
    end
  end

  always_comb begin
    tx_count_next = tx_count;
    if (tx_push && !tx_pop)      tx_count_next = tx_count + CW'(1);
    else if (!tx_push && tx_pop) tx_count_next = tx_count - CW'(1);
    rx_count_next = rx_count;
    if (rx_push && !rx_pop)      rx_count_next = rx_count + CW'(1);
    else if (!rx_push && rx_pop) rx_count_next = rx_count - CW'(1);
    irq_en_next = irq_en_wr ? i_write_data[1:0] : irq_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
      resp_data   <= '0;
      resp_status <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
      irq_en   <= irq_en_next;
      // Interrupt reflects the state after this edge's pushes/pops and enable write.
      irq <= (irq_en_next[0] && (rx_count_next != '0)) ||
             (irq_en_next[1] && (tx_count_next == '0));
      if (access) begin
        resp_data   <= rdata;
        resp_status <= (illegal || (FLOW_ERROR && (tx_overflow || rx_underflow))) ? 2'b10 : 2'b00;
      end else begin
        resp_data   <= '0;
        resp_status <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= tx_wdata;
    if (rx_push) rx_mem[rx_wptr] <= i_rx_data;
  end
endmodule
